// File: rtl/res_to_bcd_pkg.sv
// Shared types and constants for the result-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package res_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INT  = 2'd1,
    FRAC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] SIGN_NEG = 4'hA;
  localparam logic [3:0] SIGN_POS = 4'h0;
  localparam logic [3:0] BLANK    = 4'hF;

  // Sign nibble plus 14 value digits.
  localparam int NDIGITS     = 15;
  localparam int FRAC_DIGITS = 4;

endpackage

// File: rtl/res_to_bcd_if.sv
// Request/result bundle between the ALU result register and the BCD converter.
// Latency: n/a (wires only).
// Backpressure: none; i_ce is a start strobe, done/o_bcd are level outputs.
// Ports: i_val (M), i_ce, is_fixed, is_signed from master; done, o_bcd (BCD_WIDTH) from slave.
interface res_to_bcd_if #(
  parameter int M         = 24,
  parameter int BCD_WIDTH = 60
) ();

  logic [M-1:0]         i_val;
  logic                 i_ce;
  logic                 is_fixed;
  logic                 is_signed;
  logic                 done;
  logic [BCD_WIDTH-1:0] o_bcd;

  modport master (
    output i_val, i_ce, is_fixed, is_signed,
    input  done, o_bcd
  );

  modport slave (
    input  i_val, i_ce, is_fixed, is_signed,
    output done, o_bcd
  );

endinterface

// File: rtl/bcd_add3_shift.sv
// One double-dabble step: add 3 to every digit >= 5, then shift left one bit taking bit_in.
// Latency: combinational.
// Backpressure: none.
// Ports: din (14 BCD digits), bit_in (next binary bit, MSB first), dout (updated digits).
module bcd_add3_shift
  import res_to_bcd_pkg::*;
(
  input  logic [4*(NDIGITS-1)-1:0] din,
  input  logic                     bit_in,
  output logic [4*(NDIGITS-1)-1:0] dout
);

  localparam int W = 4*(NDIGITS-1);

  logic [W-1:0] adj;

  always_comb begin
    adj = din;
    for (int i = 0; i < NDIGITS-1; i++) begin
      if (din[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = din[4*i +: 4] + 4'd3;
      end
    end
    // The top digit never overflows because the magnitude is range-limited,
    // so the bit shifted out is always zero.
    dout = (adj << 1) | W'(bit_in);
  end

endmodule

// File: rtl/res_to_bcd.sv
// Converts a signed/unsigned integer or fixed-point result into 15-nibble packed BCD (sign + 14 digits).
// Latency: done/o_bcd registered M+1 cycles after start (integer) or M-I_FRAC+FRAC_DIGITS+1 (fixed).
// Backpressure: none; i_ce only accepted in IDLE/DONE, ignored while converting.
// Ports: CLK, RST (sync active-low), bus (res_to_bcd_if.slave: i_val, i_ce, is_fixed, is_signed, done, o_bcd).
// Build option: define RES_TO_BCD_BLANK_EN to blank leading integer zeros and the positive sign with 4'hF.
module res_to_bcd
  import res_to_bcd_pkg::*;
#(
  parameter int M         = 24,
  parameter int I_FRAC    = 8,
  parameter int BCD_WIDTH = 60
) (
  input  logic          CLK,
  input  logic          RST,
  res_to_bcd_if.slave   bus
);

  localparam int IDW = 4*(NDIGITS-1);   // integer/value digit field
  localparam int FDW = 4*FRAC_DIGITS;   // fraction digit field
  localparam int FW  = I_FRAC + 4;      // fraction times ten
  localparam int CW  = $clog2(M + 1);   // step counter

  if (BCD_WIDTH != 4*NDIGITS || M > 46 || I_FRAC < 1 || I_FRAC >= M || M - I_FRAC > 33) begin : g_param_err
    $error("res_to_bcd: illegal parameter combination");
  end

  state_t                 state_q, state_d;
  logic                   fixed_q, fixed_d;
  logic                   neg_q, neg_d;
  logic [M-1:0]           sh_q, sh_d;        // magnitude bits still to feed, MSB first
  logic [IDW-1:0]         dig_q, dig_d;      // double-dabble accumulator
  logic [I_FRAC-1:0]      frac_q, frac_d;    // remaining binary fraction
  logic [FDW-1:0]         fd_q, fd_d;        // fraction digits, first digit ends up MS
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [BCD_WIDTH-1:0]   bcd_q, bcd_d;

  logic                   neg_in;
  logic [M-1:0]           mag_in;
  logic [CW-1:0]          n_int;
  logic [IDW-1:0]         dig_sh;
  logic [FW-1:0]          prod;
  logic [IDW-1:0]         res_dig;
  logic [3:0]             res_sign;

  // Two's-complement negate in M bits; the most negative value lands on 2^(M-1) unsigned.
  assign neg_in = bus.is_signed & bus.i_val[M-1];
  assign mag_in = neg_in ? -bus.i_val : bus.i_val;

  assign n_int  = fixed_q ? CW'(M - I_FRAC) : CW'(M);
  assign prod   = (FW'(frac_q) << 3) + (FW'(frac_q) << 1);

  bcd_add3_shift u_add3 (
    .din    (dig_q),
    .bit_in (sh_q[M-1]),
    .dout   (dig_sh)
  );

  // Final digit layout and optional leading-zero blanking, evaluated in the completion cycle.
  always_comb begin
    int  lo;
    logic lead;
    res_dig  = fixed_q ? {dig_q[IDW-FDW-1:0], fd_q} : dig_q;
    res_sign = neg_q ? SIGN_NEG : SIGN_POS;
    lo       = fixed_q ? FRAC_DIGITS : 0;
    lead     = 1'b1;
`ifdef RES_TO_BCD_BLANK_EN
    // Walk the integer field from its top digit down, stopping above the units digit.
    for (int i = NDIGITS-2; i > 0; i--) begin
      if (i > lo) begin
        if (lead && res_dig[4*i +: 4] == 4'd0) begin
          res_dig[4*i +: 4] = BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
    res_sign = neg_q ? SIGN_NEG : BLANK;
`else
    if (lead && lo < 0) begin
      res_sign = BLANK;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    fixed_d = fixed_q;
    neg_d   = neg_q;
    sh_d    = sh_q;
    dig_d   = dig_q;
    frac_d  = frac_q;
    fd_d    = fd_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    bcd_d   = bcd_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.i_ce) begin
          state_d = INT;
          fixed_d = bus.is_fixed;
          neg_d   = neg_in;
          // Fixed mode feeds only the integer bits, left-aligned so the MSB goes first.
          sh_d    = bus.is_fixed ? {mag_in[M-1:I_FRAC], {I_FRAC{1'b0}}} : mag_in;
          frac_d  = mag_in[I_FRAC-1:0];
          dig_d   = '0;
          fd_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      INT: begin
        if (cnt_q < n_int) begin
          dig_d = dig_sh;
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + CW'(1);
          if (fixed_q && cnt_q == n_int - CW'(1)) begin
            state_d = FRAC;
            cnt_d   = '0;
          end
        end else begin
          bcd_d   = {res_sign, res_dig};
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      FRAC: begin
        if (cnt_q < CW'(FRAC_DIGITS)) begin
          // Truncating decimal expansion: integer part of f*10 is the next digit.
          fd_d   = {fd_q[FDW-5:0], prod[FW-1:I_FRAC]};
          frac_d = prod[I_FRAC-1:0];
          cnt_d  = cnt_q + CW'(1);
        end else begin
          bcd_d   = {res_sign, res_dig};
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      fixed_q <= 1'b0;
      neg_q   <= 1'b0;
      sh_q    <= '0;
      dig_q   <= '0;
      frac_q  <= '0;
      fd_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      fixed_q <= fixed_d;
      neg_q   <= neg_d;
      sh_q    <= sh_d;
      dig_q   <= dig_d;
      frac_q  <= frac_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign bus.done  = done_q;
  assign bus.o_bcd = bcd_q;

endmodule

// File: tb/tb_res_to_bcd.sv
// Directed bench for res_to_bcd: vector table plus reset/restart and ignored-strobe sequences.
module tb_res_to_bcd;

  logic clk;
  logic rst;

  res_to_bcd_if #(.M(24), .BCD_WIDTH(60)) bus ();

  res_to_bcd #(.M(24), .I_FRAC(8), .BCD_WIDTH(60)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] val;
    logic        fx;
    logic        sg;
    logic [59:0] bcd;
    int          lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start a conversion, optionally pulse i_ce with junk inputs at step glitch,
  // then measure cycles to done and compare the result.
  task automatic run_conv(input vec_t v, input int glitch);
    int c;
    int lat;
    @(negedge clk);
    bus.i_val     = v.val;
    bus.is_fixed  = v.fx;
    bus.is_signed = v.sg;
    bus.i_ce      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ce = 1'b0;
    chk({v.name, "_done_clr"}, 64'(bus.done), 64'd0);
    c   = 0;
    lat = 0;
    while (lat == 0 && c < 60) begin
      if (c + 1 == glitch) begin
        bus.i_ce      = 1'b1;
        bus.i_val     = 24'h5A5A5A;
        bus.is_fixed  = ~v.fx;
        bus.is_signed = ~v.sg;
      end
      @(posedge clk);
      c++;
      @(negedge clk);
      bus.i_ce      = 1'b0;
      bus.i_val     = v.val;
      bus.is_fixed  = v.fx;
      bus.is_signed = v.sg;
      if (bus.done) lat = c;
    end
    chk({v.name, "_latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, "_bcd"}, 64'(bus.o_bcd), 64'(v.bcd));
  endtask

  vec_t vecs[10];

  initial begin
    int seen;
    vecs[0] = '{"u_int_123456", 24'd123456,  1'b0, 1'b0, 60'h000000000123456, 25};
    vecs[1] = '{"s_int_m128",   24'hFFFF80,  1'b0, 1'b1, 60'hA00000000000128, 25};
    vecs[2] = '{"u_fix_2p5",    24'h000280,  1'b1, 1'b0, 60'h000000000025000, 21};
    vecs[3] = '{"s_fix_m1p5",   24'hFFFE80,  1'b1, 1'b1, 60'hA00000000015000, 21};
    vecs[4] = '{"u_fix_lsb",    24'h000001,  1'b1, 1'b0, 60'h000000000000039, 21};
    vecs[5] = '{"u_int_max",    24'hFFFFFF,  1'b0, 1'b0, 60'h000000016777215, 25};
    vecs[6] = '{"s_int_min",    24'h800000,  1'b0, 1'b1, 60'hA00000008388608, 25};
    vecs[7] = '{"u_fix_max",    24'hFFFFFF,  1'b1, 1'b0, 60'h000000655359960, 21};
    vecs[8] = '{"s_int_m1",     24'hFFFFFF,  1'b0, 1'b1, 60'hA00000000000001, 25};
    vecs[9] = '{"s_fix_min",    24'h800000,  1'b1, 1'b1, 60'hA00000327680000, 21};

    rst           = 1'b0;
    bus.i_val     = '0;
    bus.i_ce      = 1'b0;
    bus.is_fixed  = 1'b0;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_bcd", 64'(bus.o_bcd), 64'd0);
    rst = 1'b1;

    // Back-to-back vectors: each one after the first starts from DONE.
    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i], 0);
    end

    // Strobe with different inputs mid-conversion must be ignored.
    run_conv(vecs[0], 5);
    run_conv(vecs[3], 12);

    // Reset at cycle 10 of a conversion: outputs clear, no later done.
    @(negedge clk);
    bus.i_val     = 24'hFFFFFF;
    bus.is_fixed  = 1'b0;
    bus.is_signed = 1'b0;
    bus.i_ce      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ce = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_bcd", 64'(bus.o_bcd), 64'd0);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.o_bcd != 60'd0) seen = 1;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);

    // Restart from IDLE after the abort.
    run_conv(vecs[2], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/res_to_bcd.md
Name: res_to_bcd

Overview:
- Converts a calculator result word into a 15-digit packed BCD display word for the seven-segment/LCD formatter.
- Input may be integer or fixed-point with I_FRAC fraction bits, and unsigned or two's-complement.
- Sequential conversion: shift-add-3 (double dabble) for the integer part, multiply-by-10 for the fraction.
- Sits between the ALU result register and the display driver.

Parameters:
- M, 24: input word width.
- I_FRAC, 8: fraction bits when is_fixed=1.
- BCD_WIDTH, 60: output width. Must equal 60, giving 15 nibbles.
- FRAC_DIGITS, 4: decimal fraction digits produced in fixed mode (local constant; not overridable).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-low reset (asserted when 0).
- i_val  in  M  result to convert.
- i_ce  in  1  start strobe; sampled only when idle or done.
- is_fixed  in  1  1 = i_val is fixed-point with I_FRAC fraction bits.
- is_signed  in  1  1 = i_val is two's-complement.
- done  out  1  conversion complete; o_bcd valid.
- o_bcd  out  BCD_WIDTH  nibble 14 = sign, nibbles 13..0 = digits, MS first.

Behaviour:
- Reset (RST=0 at a clock edge): state IDLE, done=0, o_bcd=0, internal registers cleared. Reset applied mid-conversion aborts the conversion with no output update.
- States: IDLE -> INT (double dabble) -> FRAC (fixed mode only) -> DONE.
  - DONE -> INT on i_ce=1; otherwise DONE holds.
  - i_ce is ignored in INT and FRAC.
- Start edge E0 (i_ce=1 in IDLE or DONE):
  - Latch is_fixed and is_signed.
  - neg = is_signed & i_val[M-1].
  - Latch magnitude = neg ? -i_val : i_val as unsigned M bits. -2^(M-1) maps correctly to 2^(M-1).
  - Clear done.
- INT: one magnitude bit per cycle, MSB first, shifted into the BCD digit register.
  - Before each shift, add 3 to every digit ≥5.
  - Integer mode: all M bits over M cycles.
  - Fixed mode: only the upper M-I_FRAC bits over M-I_FRAC cycles.
- FRAC (fixed mode): FRAC_DIGITS cycles. Each cycle: f = f*10, emit f[I_FRAC+3:I_FRAC] as the next digit, keep the low I_FRAC bits. This is truncation, not rounding.
- Digit placement:
  - Integer mode: nibbles 13..0 = integer value.
  - Fixed mode: nibbles 13..4 = integer part, nibbles 3..0 = fraction.
  - No point marker is emitted; the consumer uses is_fixed.
- Sign nibble: 4'hA if neg, 4'h0 otherwise.
- Latency: N = M (integer) or (M-I_FRAC)+FRAC_DIGITS (fixed).
  - o_bcd and done=1 are registered on edge E0+N+1.
  - M=24, I_FRAC=8: 25 cycles integer, 21 cycles fixed.
- o_bcd changes only at completion and holds between conversions. done stays high until reset or the next start.
- Range requirements:
  - M ≤ 46, so the integer magnitude fits 14 digits.
  - M-I_FRAC ≤ 33, so the fixed integer part fits 10 digits.
  - Violations are a parameter error.

Optional Feature:
- Macro: RES_TO_BCD_BLANK_EN.
- Defined:
  - Leading zero digits of the integer field become 4'hF (blank).
  - The units digit is never blanked (nibble 0 in integer mode, nibble 4 in fixed mode).
  - Positive sign nibble is 4'hF instead of 4'h0.
  - Blanking is applied in the completion cycle; latency is unchanged.
- Undefined: zeros are shown as 0, as specified above.

Decomposition:
- Package res_to_bcd_pkg holds:
  - the state enum (IDLE, INT, FRAC, DONE);
  - SIGN_NEG=4'hA, SIGN_POS=4'h0, BLANK=4'hF;
  - NDIGITS=15 and FRAC_DIGITS=4.
- One combinational sub-module, bcd_add3_shift: 14-digit add-3 correction plus 1-bit shift-in, instantiated once in res_to_bcd.

Test Plan:
- Unsigned integer 24'd123456, is_fixed=0, is_signed=0 -> after 25 cycles done=1, o_bcd=60'h000000000123456.
- Signed integer 24'hFFFF80 (-128), is_signed=1 -> o_bcd=60'hA00000000000128.
- Fixed unsigned 24'h000280 (2.5) -> after 21 cycles o_bcd=60'h000000000025000.
- Fixed signed 24'hFFFE80 (-1.5) -> o_bcd=60'hA00000000015000.
- Fixed 24'h000001 -> 60'h000000000000039 (truncation).
- Unsigned integer 24'hFFFFFF -> 60'h000000016777215.
- Signed integer 24'h800000 -> 60'hA00000008388608.
- Reset and restart:
  - RST=0 at cycle 10 of a conversion -> done=0, o_bcd=0 next edge, no later done.
  - i_ce pulsed mid-conversion -> ignored.
  - i_ce in DONE -> done drops and a new result follows.
